// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared definitions for the bit-serial adder controller:
//               FSM state encoding and the default operand width.
// Ports       : none (package)
// Macros      : SERIAL_ADD_OVF_EN (consumed by the interface and top level)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  // Default operand width in bits (legal range 1..32).
  localparam int c_width_default = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Operand/result handshake bundle for serial_add_ctrl.
//               master : producer of operands and consumer of results
//               slave  : the serial adder itself
// Signals     : in_valid/in_ready, a, b, ci   - operand channel
//               out_valid/out_ready, sum, co  - result channel
//               ovf                           - signed overflow (only when
//                                               SERIAL_ADD_OVF_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = c_width_default
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );

endinterface : serial_add_ctrl_if
`default_nettype wire

// File: rtl/full_add_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_add_cell
// Description : One-bit combinational full adder used as the serial datapath.
// Ports       : a, b, ci (in)  - operand bits and carry-in
//               s, co    (out) - sum bit and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule : full_add_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder. Accepts an operand pair plus carry-in,
//               adds one bit per clock LSB first through a single full-adder
//               cell, then presents sum/co until the consumer takes them.
//               States: IDLE (accepting) -> RUN (WIDTH cycles) -> DONE.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - serial_add_ctrl_if.slave (operand/result handshake)
// Parameters  : WIDTH  - operand width, 1..32
// Macros      : SERIAL_ADD_OVF_EN - adds the signed-overflow output ovf
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  // Counter sized to hold WIDTH itself so the final increment never wraps.
  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_cell_s;
  logic               w_cell_co;
  logic [WIDTH:0]     w_sum_cat;
  logic               w_last;
  logic               w_in_ready;
  logic               w_out_valid;

  full_add_cell u_cell (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_cell_s),
    .co (w_cell_co)
  );

  // New sum bit enters at the MSB; concatenate-and-slice keeps WIDTH=1 legal.
  assign w_sum_cat = {w_cell_s, r_sum};
  assign w_last    = (r_cnt == c_last_bit);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        // Returning to IDLE here; the accept can only happen one edge later.
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.ci;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= w_sum_cat[WIDTH:1];
          r_carry <= w_cell_co;
          r_cnt   <= r_cnt + c_cnt_one;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the MSB cycle r_carry is the carry into bit WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= r_carry ^ w_cell_co;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  // After the last RUN edge the carry register holds the carry out of the MSB.
  assign bus.co        = r_carry;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl. Two instances:
//               WIDTH=8 (main) and WIDTH=1 (degenerate width). Results are
//               compared against plain arithmetic A+B+ci. Latency is counted
//               in rising edges with the accepting edge counted as edge 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  serial_add_ctrl_if #(.WIDTH(8)) b8 ();
  serial_add_ctrl_if #(.WIDTH(1)) b1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference: full-precision arithmetic.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    return (a[7] == b[7]) && (s[7] != a[7]);
  endfunction

  // Drives one operation on the WIDTH=8 instance and reports what it saw.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input int hold, input bit noise,
                       output logic [7:0] s, output logic c, output logic o,
                       output int lat, output bit held_ok, output bit idle_after);
    @(negedge clk);
    b8.in_valid = 1'b1; b8.a = a; b8.b = b; b8.ci = ci; b8.out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    while (b8.out_valid !== 1'b1 && lat < 40) begin
      if (noise) begin
        b8.in_valid = 1'($urandom_range(0, 1));
        b8.a = 8'($urandom); b8.b = 8'($urandom); b8.ci = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s = b8.sum; c = b8.co;
`ifdef SERIAL_ADD_OVF_EN
    o = b8.ovf;
`else
    o = 1'b0;
`endif
    held_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      if (noise) begin
        b8.in_valid = 1'($urandom_range(0, 1));
        b8.a = 8'($urandom); b8.b = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (b8.out_valid !== 1'b1 || b8.sum !== s || b8.co !== c) held_ok = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      if (b8.ovf !== o) held_ok = 1'b0;
`endif
    end
    b8.out_ready = 1'b1;
    b8.in_valid  = noise;
    b8.a = 8'($urandom); b8.b = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    idle_after = (b8.in_ready === 1'b1) && (b8.out_valid === 1'b0);
    b8.out_ready = 1'b0;
    b8.in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    n_run++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs8: got ready=%b valid=%b required ready=1 valid=0", b8.in_ready, b8.out_valid);
    end
    n_run++;
    if (b8.sum !== 8'h00 || b8.co !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out8: got sum=%h co=%b required sum=00 co=0", b8.sum, b8.co);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_run++;
    if (b8.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf8: got %b required 0", b8.ovf);
    end
`endif
    n_run++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.sum !== 1'b0 || b1.co !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w1: got ready=%b valid=%b sum=%b co=%b required 1 0 0 0",
               b1.in_ready, b1.out_valid, b1.sum, b1.co);
    end
  endtask

  task automatic test_directed;
    logic [16:0] vec [4];
    logic [7:0] s; logic c, o; int lat; bit h, idl; logic [8:0] e;
    vec[0] = {8'h0F, 8'h01, 1'b0};
    vec[1] = {8'hFF, 8'h01, 1'b0};
    vec[2] = {8'hFF, 8'hFF, 1'b1};
    vec[3] = {8'h7F, 8'h01, 1'b0};
    for (int i = 0; i < 5; i++) begin
      logic [7:0] va, vb; logic vc;
      if (i < 4) begin
        va = vec[i][16:9]; vb = vec[i][8:1]; vc = vec[i][0];
      end else begin
        va = 8'h80; vb = 8'h80; vc = 1'b0;
      end
      do_op(va, vb, vc, 0, 1'b0, s, c, o, lat, h, idl);
      e = ref_add(va, vb, vc);
      n_run++;
      if (lat !== 9) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d edges required 9", i, lat);
      end
      n_run++;
      if (s !== e[7:0] || c !== e[8]) begin
        n_fail++;
        $display("FAIL dir_sum[%0d]: got sum=%h co=%b required sum=%h co=%b", i, s, c, e[7:0], e[8]);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_run++;
      if (o !== ref_ovf(va, vb, e[7:0])) begin
        n_fail++;
        $display("FAIL dir_ovf[%0d]: got %b required %b", i, o, ref_ovf(va, vb, e[7:0]));
      end
`endif
    end
  endtask

  task automatic test_random;
    logic [7:0] s; logic c, o; int lat; bit h, idl; logic [8:0] e;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb; logic rc; bit nz; int hd;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      nz = 1'($urandom_range(0, 1)); hd = $urandom_range(0, 3);
      do_op(ra, rb, rc, hd, nz, s, c, o, lat, h, idl);
      e = ref_add(ra, rb, rc);
      n_run++;
      if (lat !== 9 || s !== e[7:0] || c !== e[8]) begin
        n_fail++;
        $display("FAIL rnd[%0d]: got lat=%0d sum=%h co=%b required lat=9 sum=%h co=%b",
                 i, lat, s, c, e[7:0], e[8]);
      end
      n_run++;
      if (h !== 1'b1 || idl !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_hs[%0d]: got held=%b idle_after=%b required 1 1", i, h, idl);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_run++;
      if (o !== ref_ovf(ra, rb, e[7:0])) begin
        n_fail++;
        $display("FAIL rnd_ovf[%0d]: got %b required %b", i, o, ref_ovf(ra, rb, e[7:0]));
      end
`endif
    end
  endtask

  task automatic test_hold;
    logic [7:0] s; logic c, o; int lat; bit h, idl; logic [8:0] e;
    do_op(8'h5A, 8'h33, 1'b1, 5, 1'b1, s, c, o, lat, h, idl);
    e = ref_add(8'h5A, 8'h33, 1'b1);
    n_run++;
    if (s !== e[7:0] || c !== e[8] || lat !== 9) begin
      n_fail++;
      $display("FAIL hold_result: got sum=%h co=%b lat=%0d required sum=%h co=%b lat=9", s, c, lat, e[7:0], e[8]);
    end
    n_run++;
    if (h !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_stable: got held=%b required 1", h);
    end
    n_run++;
    if (idl !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_no_accept_on_release: got idle=%b required 1", idl);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] s; logic c, o; int lat; bit h, idl; bit seen;
    // Abort in RUN, after three bits have been processed.
    @(negedge clk);
    b8.in_valid = 1'b1; b8.a = 8'hAB; b8.b = 8'hCD; b8.ci = 1'b1; b8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.sum !== 8'h00 || b8.co !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_run: got ready=%b valid=%b sum=%h co=%b required 1 0 00 0",
               b8.in_ready, b8.out_valid, b8.sum, b8.co);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    b8.out_ready = 1'b0;
    // First edge after release must accept.
    do_op(8'h03, 8'h04, 1'b0, 1, 1'b0, s, c, o, lat, h, idl);
    n_run++;
    if (s !== 8'h07 || c !== 1'b0 || lat !== 9) begin
      n_fail++;
      $display("FAIL after_abort: got sum=%h co=%b lat=%0d required sum=07 co=0 lat=9", s, c, lat);
    end
    // Abort in DONE; the result must never reappear.
    @(negedge clk);
    b8.in_valid = 1'b1; b8.a = 8'h11; b8.b = 8'h22; b8.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.sum !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_done: got valid=%b ready=%b sum=%h required 0 1 00", b8.out_valid, b8.in_ready, b8.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (b8.out_valid !== 1'b0) seen = 1'b1;
    end
    n_run++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_result: got out_valid seen=%b required 0", seen);
    end
  endtask

  task automatic test_width1;
    for (int i = 0; i < 8; i++) begin
      logic va, vb, vc; int lat; int tot; logic es, ec;
      va = i[2]; vb = i[1]; vc = i[0];
      tot = int'(va) + int'(vb) + int'(vc);
      es = tot[0]; ec = tot[1];
      @(negedge clk);
      b1.in_valid = 1'b1; b1.a = va; b1.b = vb; b1.ci = vc; b1.out_ready = 1'b0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      b1.in_valid = 1'b0;
      while (b1.out_valid !== 1'b1 && lat < 10) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      n_run++;
      if (lat !== 2 || b1.sum !== es || b1.co !== ec) begin
        n_fail++;
        $display("FAIL w1[%0d]: got lat=%0d sum=%b co=%b required lat=2 sum=%b co=%b",
                 i, lat, b1.sum, b1.co, es, ec);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_run++;
      if (b1.ovf !== ((va == vb) && (es != va))) begin
        n_fail++;
        $display("FAIL w1_ovf[%0d]: got %b required %b", i, b1.ovf, (va == vb) && (es != va));
      end
`endif
      b1.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b1.out_ready = 1'b0;
    end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.ci = 1'b0; b8.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.ci = 1'b0; b1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_directed;
    test_random;
    test_hold;
    test_reset_abort;
    test_width1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair and carry-in present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A, unsigned/two's-complement agnostic.
REQ-007 b  input  WIDTH  operand B.
REQ-008 ci  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  A+B+ci modulo 2^WIDTH.
REQ-012 co  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a rising edge, latch a, b into shift registers, carry register <= ci, bit counter <= 0, go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle feed LSB of A, LSB of B and carry register to the full-adder cell, shift A/B right by one, shift sum register right inserting cell sum at MSB, carry register <= cell carry, counter += 1.
REQ-017 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 transitions to DONE.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge.
REQ-019 DONE: out_valid=1, in_ready=0; sum, co (and ovf) stable and held while out_ready=0.
REQ-020 DONE with out_ready=1 at a rising edge SHALL return to IDLE; no operand accept on that same edge (throughput one result per WIDTH+2 cycles minimum).
REQ-021 in_valid during RUN or DONE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-022 Counter width SHALL be ceil(log2(WIDTH+1)) bits, with no wrap before terminal count; WIDTH=1 SHALL yield one RUN cycle.
REQ-023 sum, co SHALL reflect only the last completed operation; intermediate values never visible with out_valid=1.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, co=0, ovf=0, counter=0, carry=0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation; no result is ever presented for it.
REQ-026 First accept after rst_n deasserts SHALL be possible on the first rising edge.

Configuration
REQ-027 Macro SERIAL_ADD_OVF_EN defined: port ovf exists, ovf = carry into bit WIDTH-1 XOR co, valid with out_valid, held in DONE.
REQ-028 Macro undefined: port ovf and its register absent; all other behaviour identical.

Structure
REQ-029 Package serial_add_pkg SHALL hold the state encoding (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-030 One sub-module full_add_cell (inputs a, b, ci; outputs s, co; purely combinational) SHALL perform the per-bit addition; serial_add_ctrl instantiates it once.

Verification (WIDTH=8)
REQ-031 a=0x0F, b=0x01, ci=0 -> sum=0x10, co=0, out_valid exactly 9 edges after accept.
REQ-032 a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1; a=0xFF, b=0xFF, ci=1 -> sum=0xFF, co=1.
REQ-033 With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1, co=0; a=0x80, b=0x80 -> sum=0x00, ovf=1, co=1.
REQ-034 out_ready=0 for 5 cycles in DONE -> sum/co/out_valid held; in_valid pulses with other operands during RUN/DONE -> ignored, result unchanged.
REQ-035 rst_n low at RUN cycle 4 -> outputs zero, in_ready=1 at once; next op a=0x03, b=0x04 -> sum=0x07.
REQ-036 WIDTH=1: a=1, b=1, ci=1 -> sum=1, co=1, out_valid 2 edges after accept.
